// File: rtl/prog_iram_pkg.sv
// prog_iram_pkg: shared FSM encoding, default fill word and a clog2 helper
// for the loadable instruction memory.
package prog_iram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_FILL_WORD = 16'h0000;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32'd32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prog_iram_if.sv
// prog_iram_if: valid/ready program loader port.
//   LD_START/LD_VALID/LD_DATA/LD_LAST : loader -> memory
//   LD_READY/LD_DONE/LD_ERR/LD_SUM    : memory -> loader
interface prog_iram_if #(
  parameter int unsigned DATA_W = 16
);
  logic              LD_START;
  logic              LD_VALID;
  logic              LD_READY;
  logic [DATA_W-1:0] LD_DATA;
  logic              LD_LAST;
  logic              LD_DONE;
  logic              LD_ERR;
  logic [DATA_W-1:0] LD_SUM;

  modport master (
    output LD_START, LD_VALID, LD_DATA, LD_LAST,
    input  LD_READY, LD_DONE, LD_ERR, LD_SUM
  );

  modport slave (
    input  LD_START, LD_VALID, LD_DATA, LD_LAST,
    output LD_READY, LD_DONE, LD_ERR, LD_SUM
  );
endinterface

// File: rtl/iram_array.sv
// iram_array: DEPTH x DATA_W storage, one synchronous write port and one
// combinational read port. Contents are not reset.
//   CLK, we/waddr/wdata : write port
//   raddr/rdata         : asynchronous read port
module iram_array
  import prog_iram_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned AW     = 7
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_iram.sv
// prog_iram: loadable instruction memory. Sweeps FILL_WORD through the
// array after reset, then accepts programs over a valid/ready port.
//   CLK, RESET : clock, async active-high reset
//   ADDR/Q     : combinational CPU fetch (byte address in, word out)
//   RUN        : program valid, CPU may execute (IDLE only)
//   ld         : loader port (start/valid/ready/data/last, done/err/sum)
module prog_iram
  import prog_iram_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       DEPTH     = 128,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(DEFAULT_FILL_WORD)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              RUN,
  prog_iram_if.slave        ld
);

  localparam int unsigned PTR_W = clog2(DEPTH + 1);
  localparam int unsigned AW    = (clog2(DEPTH) == 0) ? 1 : clog2(DEPTH);
  localparam int unsigned SHIFT = clog2(DATA_W / 8);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  state_t            state;
  logic [PTR_W-1:0]  clr_ptr;
  logic [PTR_W-1:0]  wptr;
  logic              run_q;
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] sum_q;

  logic              accept_c;
  logic              we_c;
  logic [AW-1:0]     waddr_c;
  logic [DATA_W-1:0] wdata_c;
  logic [ADDR_W-1:0] idx_c;
  logic              in_range_c;
  logic [AW-1:0]     raddr_c;
  logic [DATA_W-1:0] rdata_c;

  // Write-port muxing: the clear sweep owns the port in CLEAR; in LOAD a
  // handshake writes only when not pre-empted by LD_START and not overflowing.
  always_comb begin
    accept_c = (state == ST_LOAD) && !ld.LD_START && ld.LD_VALID && ready_q;
    we_c     = (state == ST_CLEAR) || (accept_c && (wptr < DEPTH_P));
    waddr_c  = (state == ST_CLEAR) ? AW'(clr_ptr) : AW'(wptr);
    wdata_c  = (state == ST_CLEAR) ? FILL_WORD : ld.LD_DATA;
  end

  // Fetch path: drop sub-word address bits, range check, and mask to
  // FILL_WORD whenever the program is not valid.
  always_comb begin
    idx_c      = ADDR >> SHIFT;
    in_range_c = 32'(idx_c) < DEPTH;
    raddr_c    = in_range_c ? AW'(idx_c) : '0;
    Q          = (run_q && in_range_c) ? rdata_c : FILL_WORD;
  end

  iram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .CLK   (CLK),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (wdata_c),
    .raddr (raddr_c),
    .rdata (rdata_c)
  );

  // Control FSM with registered status outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      wptr    <= '0;
      run_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + PTR_W'(1);
          if (clr_ptr == LAST_P) begin
            state <= ST_IDLE;
            run_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (ld.LD_START) begin
            state   <= ST_LOAD;
            wptr    <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld.LD_START) begin
            wptr  <= '0;
            sum_q <= '0;
            err_q <= 1'b0;
          end else if (accept_c) begin
            if (wptr < DEPTH_P) begin
              wptr  <= wptr + PTR_W'(1);
              sum_q <= sum_q ^ ld.LD_DATA;
            end else begin
              err_q <= 1'b1;
            end
            if (ld.LD_LAST) begin
              state   <= ST_IDLE;
              done_q  <= 1'b1;
              run_q   <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_ptr <= '0;
          run_q   <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign RUN         = run_q;
  assign ld.LD_READY = ready_q;
  assign ld.LD_DONE  = done_q;
  assign ld.LD_ERR   = err_q;
  assign ld.LD_SUM   = sum_q;

endmodule

// File: tb/tb_prog_iram.sv
// tb_prog_iram: drives one loader stimulus into a DEPTH=128 and a DEPTH=4
// instance side by side and compares both against an array/queue model.
module tb_prog_iram;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  ADDR;
  logic [15:0] q0, q1;
  logic        run0, run1;

  prog_iram_if #(.DATA_W(16)) ld0 ();
  prog_iram_if #(.DATA_W(16)) ld1 ();

  assign ld1.LD_START = ld0.LD_START;
  assign ld1.LD_VALID = ld0.LD_VALID;
  assign ld1.LD_DATA  = ld0.LD_DATA;
  assign ld1.LD_LAST  = ld0.LD_LAST;

  prog_iram #(.DATA_W(16), .DEPTH(128), .ADDR_W(8), .FILL_WORD(16'h0000)) dut0 (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .Q(q0), .RUN(run0), .ld(ld0.slave));

  prog_iram #(.DATA_W(16), .DEPTH(4), .ADDR_W(8), .FILL_WORD(16'h0000)) dut1 (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .Q(q1), .RUN(run1), .ld(ld1.slave));

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: contents, write pointer, checksum, error per instance.
  logic [15:0] m0 [128];
  logic [15:0] m1 [4];
  int          wp0, wp1;
  logic [15:0] s0, s1;
  logic        e0, e1;
  logic [15:0] words [$];

  function automatic void model_clear();
    for (int k = 0; k < 128; k++) m0[k] = 16'h0000;
    for (int k = 0; k < 4; k++) m1[k] = 16'h0000;
  endfunction

  function automatic void model_restart();
    wp0 = 0; wp1 = 0; s0 = 16'h0; s1 = 16'h0; e0 = 1'b0; e1 = 1'b0;
  endfunction

  function automatic void model_accept(input logic [15:0] w);
    if (wp0 < 128) begin m0[wp0] = w; wp0++; s0 = s0 ^ w; end else e0 = 1'b1;
    if (wp1 < 4)   begin m1[wp1] = w; wp1++; s1 = s1 ^ w; end else e1 = 1'b1;
  endfunction

  function automatic logic [15:0] exp_q0(input logic [7:0] a);
    int idx;
    idx = int'(a) >> 1;
    return m0[idx];
  endfunction

  function automatic logic [15:0] exp_q1(input logic [7:0] a);
    int idx;
    idx = int'(a) >> 1;
    return (idx < 4) ? m1[idx] : 16'h0000;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Read every byte address on both instances (dut1 sees out-of-range too).
  task automatic readback();
    for (int a = 0; a < 256; a++) begin
      ADDR = 8'(a);
      #1;
      n_chk++;
      if (q0 !== exp_q0(ADDR)) begin
        n_fail++;
        $display("FAIL readback0 addr %0d: got %h expected %h", a, q0, exp_q0(ADDR));
      end
      n_chk++;
      if (q1 !== exp_q1(ADDR)) begin
        n_fail++;
        $display("FAIL readback1 addr %0d: got %h expected %h", a, q1, exp_q1(ADDR));
      end
    end
  endtask

  // Release reset after the next edge and follow the clear sweep; loader
  // inputs are wiggled during the first edges and must be ignored.
  task automatic sweep();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 128; i++) begin
      ADDR = 8'($urandom);
      ld0.LD_START = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      ld0.LD_VALID = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      ld0.LD_DATA  = 16'($urandom);
      #1;
      n_chk++;
      if (run0 !== 1'b0 || q0 !== 16'h0000) begin
        n_fail++;
        $display("FAIL sweep0 cycle %0d: run %b q %h expected run 0 q 0000", i, run0, q0);
      end
      n_chk++;
      if (run1 !== (i >= 4)) begin
        n_fail++;
        $display("FAIL sweep1 cycle %0d: run %b expected %b", i, run1, (i >= 4));
      end
      @(posedge CLK);
      #1;
    end
    n_chk++;
    if (run0 !== 1'b1 || ld0.LD_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_end: run %b ready %b expected run 1 ready 0", run0, ld0.LD_READY);
    end
    model_clear();
    readback();
  endtask

  task automatic check_reset_outputs();
    n_chk++;
    if ({run0, ld0.LD_READY, ld0.LD_DONE, ld0.LD_ERR} !== 4'b0000 || ld0.LD_SUM !== 16'h0 || q0 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset0: run %b rdy %b done %b err %b sum %h q %h expected all 0",
               run0, ld0.LD_READY, ld0.LD_DONE, ld0.LD_ERR, ld0.LD_SUM, q0);
    end
    n_chk++;
    if ({run1, ld1.LD_READY, ld1.LD_DONE, ld1.LD_ERR} !== 4'b0000 || ld1.LD_SUM !== 16'h0) begin
      n_fail++;
      $display("FAIL reset1: run %b rdy %b done %b err %b sum %h expected all 0",
               run1, ld1.LD_READY, ld1.LD_DONE, ld1.LD_ERR, ld1.LD_SUM);
    end
  endtask

  task automatic do_start();
    ld0.LD_START = 1'b1;
    ld0.LD_VALID = 1'($urandom_range(0, 1));
    ld0.LD_DATA  = 16'($urandom);
    ld0.LD_LAST  = 1'b0;
    tick();
    ld0.LD_START = 1'b0;
    ld0.LD_VALID = 1'b0;
    model_restart();
    n_chk++;
    if (ld0.LD_READY !== 1'b1 || ld1.LD_READY !== 1'b1 || run0 !== 1'b0) begin
      n_fail++;
      $display("FAIL start: rdy0 %b rdy1 %b run %b expected 1 1 0", ld0.LD_READY, ld1.LD_READY, run0);
    end
  endtask

  // Stream the words queue; with_last marks the final word and checks completion.
  task automatic stream(input bit stall, input bit with_last);
    int  i = 0;
    int  cyc = 0;
    bit  v;
    while (i < words.size() && cyc < 2000) begin
      v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld0.LD_VALID = v;
      ld0.LD_DATA  = v ? words[i] : 16'($urandom);
      ld0.LD_LAST  = v ? (with_last && i == words.size() - 1) : 1'($urandom_range(0, 1));
      ADDR = 8'($urandom);
      #1;
      n_chk++;
      if (ld0.LD_READY !== 1'b1 || q0 !== 16'h0000 || q1 !== 16'h0000) begin
        n_fail++;
        $display("FAIL in_load cycle %0d: rdy %b q0 %h q1 %h expected 1 0000 0000", cyc, ld0.LD_READY, q0, q1);
      end
      @(posedge CLK);
      #1;
      if (v) begin
        model_accept(words[i]);
        i++;
      end
      cyc++;
    end
    ld0.LD_VALID = 1'b0;
    ld0.LD_LAST  = 1'b0;
    n_chk++;
    if (i != words.size()) begin
      n_fail++;
      $display("FAIL stream_timeout: sent %0d expected %0d", i, words.size());
    end
    if (!stall) begin
      n_chk++;
      if (cyc != words.size()) begin
        n_fail++;
        $display("FAIL back_to_back: cycles %0d expected %0d", cyc, words.size());
      end
    end
    if (with_last) begin
      n_chk++;
      if ({ld0.LD_DONE, ld1.LD_DONE, run0, run1, ld0.LD_READY} !== 5'b11110) begin
        n_fail++;
        $display("FAIL done_cycle: done %b%b run %b%b rdy %b expected 11 11 0",
                 ld0.LD_DONE, ld1.LD_DONE, run0, run1, ld0.LD_READY);
      end
      tick();
      n_chk++;
      if (ld0.LD_DONE !== 1'b0 || ld1.LD_DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse: done %b%b expected 00", ld0.LD_DONE, ld1.LD_DONE);
      end
      n_chk++;
      if (ld0.LD_SUM !== s0 || ld0.LD_ERR !== e0) begin
        n_fail++;
        $display("FAIL status0: sum %h err %b expected %h %b", ld0.LD_SUM, ld0.LD_ERR, s0, e0);
      end
      n_chk++;
      if (ld1.LD_SUM !== s1 || ld1.LD_ERR !== e1) begin
        n_fail++;
        $display("FAIL status1: sum %h err %b expected %h %b", ld1.LD_SUM, ld1.LD_ERR, s1, e1);
      end
      readback();
    end
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int k = 0; k < n; k++) words.push_back(16'($urandom) | 16'h0001);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ADDR = 8'h00;
    ld0.LD_START = 1'b0; ld0.LD_VALID = 1'b0; ld0.LD_DATA = 16'h0; ld0.LD_LAST = 1'b0;
    #1;
    check_reset_outputs();
    sweep();
  endtask

  task automatic test_load3();
    words.delete();
    words.push_back(16'hF001); words.push_back(16'h5AFF); words.push_back(16'hF2D1);
    do_start();
    stream(1'b0, 1'b1);
    ADDR = 8'd2;
    #1;
    n_chk++;
    if (q0 !== 16'h5AFF) begin
      n_fail++;
      $display("FAIL load3_addr2: got %h expected 5aff", q0);
    end
  endtask

  task automatic test_backpressure();
    fill_words(40);
    do_start();
    stream(1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    fill_words(20);
    do_start();
    stream(1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    fill_words(6);
    do_start();
    stream(1'b1, 1'b1);
    n_chk++;
    if (ld1.LD_ERR !== 1'b1 || ld0.LD_ERR !== 1'b0 || run1 !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: err1 %b err0 %b run1 %b expected 1 0 1", ld1.LD_ERR, ld0.LD_ERR, run1);
    end
  endtask

  task automatic test_restart();
    fill_words(2);
    do_start();
    stream(1'b0, 1'b0);
    ld0.LD_START = 1'b1;
    ld0.LD_VALID = 1'b1;
    ld0.LD_DATA  = 16'hBEEF;
    ld0.LD_LAST  = 1'b1;
    tick();
    ld0.LD_START = 1'b0;
    ld0.LD_VALID = 1'b0;
    ld0.LD_LAST  = 1'b0;
    model_restart();
    n_chk++;
    if (ld0.LD_SUM !== 16'h0 || ld0.LD_READY !== 1'b1 || ld0.LD_DONE !== 1'b0 || run0 !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: sum %h rdy %b done %b run %b expected 0000 1 0 0",
               ld0.LD_SUM, ld0.LD_READY, ld0.LD_DONE, run0);
    end
    fill_words(5);
    stream(1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    fill_words(5);
    do_start();
    stream(1'b0, 1'b0);
    #3;
    RESET = 1'b1;
    #1;
    check_reset_outputs();
    sweep();
  endtask

  initial begin
    test_reset();
    test_load3();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_restart();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
